// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory access stage: bus sizes, fault codes, FSM states, funct3 encodings.
// Pure declarations; no latency or backpressure of its own.
package mem_access_unit_pkg;

   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   typedef enum logic [1:0] {
      FAULT_NONE    = 2'd0,
      FAULT_LD_MIS  = 2'd1,
      FAULT_ST_MIS  = 2'd2,
      FAULT_ILLEGAL = 2'd3
   } lsu_fault_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   // Accepted-op attributes carried from IDLE into REQ for the load extract
   typedef struct packed {
      logic       store;
      logic [2:0] funct3;
   } meta_t;

   function automatic msize_t f3_to_msize(input logic [2:0] funct3);
      return msize_t'({1'b0, funct3[1:0]});
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Lane extract plus sign/zero extend of a bus read word at a byte offset.
// Combinational, zero latency; no backpressure.
module mem_load_align
   import mem_access_unit_pkg::*;
#(
   parameter int XLEN = 64,
   localparam int NB = XLEN / 8,
   localparam int OB = $clog2(NB)
) (
   input  logic [XLEN-1:0] data,
   input  logic [OB-1:0]   offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] result
);

   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] mask;
   logic            sign_bit;

   always_comb begin
      shifted  = data >> {offset, 3'b000};
      mask     = '1;
      sign_bit = 1'b0;
      case (funct3[1:0])
         2'b00: begin
            mask     = XLEN'(8'hFF);
            sign_bit = shifted[7];
         end
         2'b01: begin
            mask     = XLEN'(16'hFFFF);
            sign_bit = shifted[15];
         end
         2'b10: begin
            mask     = XLEN'(32'hFFFF_FFFF);
            sign_bit = shifted[31];
         end
         default: begin
            mask     = '1;
            sign_bit = 1'b0;
         end
      endcase
      // funct3[2] selects zero extension; otherwise the field's top bit fills the upper lanes
      result = (shifted & mask) | ((!funct3[2] && sign_bit) ? ~mask : '0);
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: registers the access, holds a bus request until data_ok, returns an extended result.
// Latency: load/store 2+ cycles (bus dependent), faults 1 cycle; stalls the pipeline until the resp_valid cycle.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int XLEN           = 64,
   parameter int ADDR_W         = 64,
   parameter bit ALLOW_MISALIGN = 1'b0,
   localparam int NB = XLEN / 8,
   localparam int OB = $clog2(NB)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              op_valid,
   input  logic              op_store,
   input  logic [2:0]        op_funct3,
   input  logic [ADDR_W-1:0] op_addr,
   input  logic [XLEN-1:0]   op_wdata,
   input  logic              flush,
   output logic              stall,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic [1:0]        resp_fault,
   output logic              dreq_valid,
   output logic [ADDR_W-1:0] dreq_addr,
   output msize_t            dreq_size,
   output logic [NB-1:0]     dreq_strobe,
   output logic [XLEN-1:0]   dreq_data,
   input  logic              dresp_data_ok,
   input  logic [XLEN-1:0]   dresp_data
);

   lsu_state_t      state_q, state_d;
   meta_t           meta_q;
   logic            flush_q;
   logic            accept;
   logic            squash;
   logic            illegal;
   logic            misaligned;
   lsu_fault_t      fault_d;
   logic [OB-1:0]   offset;
   logic [NB-1:0]   size_lanes;
   logic [XLEN-1:0] wdata_mask;
   logic [XLEN-1:0] load_result;

   assign accept = op_valid && !flush && (state_q == ST_IDLE);
   assign offset = op_addr[OB-1:0];
   assign squash = flush || flush_q;

   always_comb begin
      size_lanes = '0;
      misaligned = 1'b0;
      case (op_funct3[1:0])
         2'b00: begin
            size_lanes = NB'(8'h01);
            misaligned = 1'b0;
         end
         2'b01: begin
            size_lanes = NB'(8'h03);
            misaligned = op_addr[0];
         end
         2'b10: begin
            size_lanes = NB'(8'h0F);
            misaligned = |op_addr[1:0];
         end
         default: begin
            size_lanes = NB'(8'hFF);
            misaligned = |op_addr[2:0];
         end
      endcase
      if (ALLOW_MISALIGN) misaligned = 1'b0;
      wdata_mask = '0;
      for (int i = 0; i < NB; i++) wdata_mask[8*i +: 8] = {8{size_lanes[i]}};
   end

   // A 32-bit datapath has no doubleword access and no lwu
   assign illegal = (op_funct3 == 3'b111) || (op_store && op_funct3[2]) ||
                    ((XLEN == 32) && ((op_funct3[1:0] == 2'b11) || (op_funct3 == F3_WU)));

   always_comb begin
      fault_d = FAULT_NONE;
      if (illegal)         fault_d = FAULT_ILLEGAL;
      else if (misaligned) fault_d = op_store ? FAULT_ST_MIS : FAULT_LD_MIS;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = (fault_d == FAULT_NONE) ? ST_REQ : ST_RESP;
         // A flushed transaction still has to finish on the bus, but reports nothing
         ST_REQ:  if (dresp_data_ok) state_d = squash ? ST_IDLE : ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      dreq_valid = (state_q == ST_REQ);
      resp_valid = (state_q == ST_RESP) && !flush;
      stall      = op_valid && (state_q != ST_RESP) && !reset;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q      <= '0;
         flush_q     <= 1'b0;
         dreq_addr   <= '0;
         dreq_size   <= MSIZE1;
         dreq_strobe <= '0;
         dreq_data   <= '0;
         resp_rdata  <= '0;
         resp_fault  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  meta_q     <= '{store: op_store, funct3: op_funct3};
                  resp_fault <= fault_d;
                  if (fault_d == FAULT_NONE) begin
                     dreq_addr   <= op_addr;
                     dreq_size   <= f3_to_msize(op_funct3);
                     dreq_strobe <= op_store ? NB'(size_lanes << offset) : '0;
                     dreq_data   <= op_store ? ((op_wdata & wdata_mask) << {offset, 3'b000}) : '0;
                  end
               end
            end
            ST_REQ: begin
               if (flush) flush_q <= 1'b1;
               if (dresp_data_ok) begin
                  flush_q     <= 1'b0;
                  dreq_addr   <= '0;
                  dreq_size   <= MSIZE1;
                  dreq_strobe <= '0;
                  dreq_data   <= '0;
                  if (!meta_q.store && !squash) resp_rdata <= load_result;
               end
            end
            ST_RESP: begin
               resp_rdata <= '0;
               resp_fault <= '0;
            end
            default: ;
         endcase
      end
   end

   mem_load_align #(
      .XLEN (XLEN)
   ) u_load_align (
      .data   (dresp_data),
      .offset (dreq_addr[OB-1:0]),
      .funct3 (meta_q.funct3),
      .result (load_result)
   );

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Parametrised memory-stage load/store unit between the pipeline M stage and the data bus. It registers each access, drives a stable bus request until data_ok, and returns a registered, lane-extracted, sign/zero-extended load result with a one-cycle done pulse. It also flags misaligned and illegal accesses without touching the bus, and supports flush. It supersedes the combinational-extract / clocked-request data memory stage.

Parameters:
XLEN, 64, data/bus width in bits; legal values are 32 and 64. Byte lanes NB = XLEN/8. Offset bits OB = log2(NB).
ADDR_W, 64, address width.
ALLOW_MISALIGN, 0, when 1 skip the alignment check and issue the access as given.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
op_valid  in  1  M stage holds a load/store; held high until resp_valid
op_store  in  1  1 = store, 0 = load
op_funct3  in  3  bit 2 = unsigned; [1:0] = size b/h/w/d
op_addr  in  ADDR_W  byte address
op_wdata  in  XLEN  store data, right-aligned
flush  in  1  squash: no new accept; pending result discarded
stall  out  1  pipeline hold request
resp_valid  out  1  one-cycle done pulse
resp_rdata  out  XLEN  extended load data; 0 for stores and faults
resp_fault  out  2  0 none, 1 load misalign, 2 store misalign, 3 illegal
dreq_valid  out  1  bus request valid
dreq_addr  out  ADDR_W  bus address (op_addr unmodified)
dreq_size  out  3  msize_t: MSIZE1/2/4/8
dreq_strobe  out  NB  byte enables; all 0 for loads
dreq_data  out  XLEN  store data shifted into its lanes
dresp_data_ok  in  1  bus completion
dresp_data  in  XLEN  bus read data

Behaviour:
- Reset: state IDLE. All outputs are 0, including dreq_valid, strobe, data, resp_*. Reset takes effect immediately (asynchronous).
- FSM: IDLE, REQ, RESP.
- IDLE, accept when op_valid & !flush & state==IDLE:
  - Illegal op: funct3==3'b111, store with funct3[2]=1, or XLEN=32 with size d / lwu. Go to RESP with fault 3.
  - Misaligned op (ALLOW_MISALIGN=0 and addr not a multiple of the access size). Go to RESP with fault 1 (load) or 2 (store).
  - Otherwise go to REQ. Register addr, size, strobe and data into the dreq_* outputs.
- Store lanes: strobe = ((1<<bytes)-1) << addr[OB-1:0]. data = op_wdata << (8*addr[OB-1:0]). Unused lanes are 0.
- REQ: dreq_valid=1. All dreq fields stay constant until the edge where dresp_data_ok=1 is sampled.
  - On that edge: clear dreq_valid, register the extracted load result, go to RESP.
  - Extraction: byte/half/word/double at the address offset. Sign-extend when funct3[2]=0, zero-extend when 1.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - Results and fault clear to 0 on leaving RESP.
- stall = op_valid & (state != RESP). stall is 0 in the resp_valid cycle so the pipeline advances on that edge.
- Latency, load with data_ok on the first REQ cycle:
  - accept at edge 0;
  - dreq_valid high in cycle 1;
  - resp_valid in cycle 2.
- Fault latency: accept at edge 0, resp_valid in cycle 1, no bus activity.
- flush:
  - In IDLE: no accept.
  - In REQ: the bus transaction cannot be withdrawn. It completes, then the FSM goes directly to IDLE with no resp_valid.
  - In RESP: suppresses resp_valid.
  - flush is sticky from REQ until completion.
- A new op may be accepted in the IDLE cycle after RESP (no back-to-back accept in RESP).
- Reset in REQ drops dreq_valid at once. The bus side tolerates an abandoned request.

Decomposition:
- Package common: msize_t and MSIZE* (existing). Add lsu_fault_t (NONE, LD_MIS, ST_MIS, ILLEGAL) and funct3 constants F3_B/H/W/D/BU/HU/WU.
- Sub-module mem_load_align: combinational lane extract plus sign/zero extend. Parameter XLEN; inputs data, offset, funct3; output result. Reusable by a future cache.

Test Plan:
- Load lb, addr 0x...1003, dresp_data 0x0123_4567_89AB_CDEF, data_ok on the first REQ cycle -> dreq_size=MSIZE1, strobe 0x00, resp_rdata 0xFFFF_FFFF_FFFF_FF89, resp_valid in cycle 2, stall high in cycles 0–1.
- Store sw, addr 0x...2004, wdata 0xDEAD_BEEF, data_ok after 3 wait cycles -> strobe 0xF0, dreq_data 0xDEAD_BEEF_0000_0000, fields stable all 4 REQ cycles, resp_rdata 0.
- Loads lh at 0x...3001 and sd at 0x...3004 -> resp_fault 1 and 2 respectively, dreq_valid never asserted, resp_valid in cycle 1.
- Load lwu with XLEN=32, and a store with funct3 = 3'b100 -> resp_fault 3, no bus request.
- Flush asserted during REQ, data_ok two cycles later -> bus completes normally, no resp_valid, next op accepted the following cycle.
- Reset asserted mid-REQ -> dreq_valid falls without a clock edge, all outputs 0. After release, a fresh lbu at offset 7 with data 0x80.. -> resp_rdata 0x80.
